// File: rtl/apb_regs_arbiter.sv
// apb_regs_arbiter
// Shares one APB master port between NoReq request/response clients using
// round-robin arbitration. Each accepted request becomes one full APB
// SETUP/ACCESS transfer. The rdata and slverr of that transfer are returned
// to the client that owned it. A watchdog ends any transfer whose slave
// never raises pready.
//
// Ports:
//   pclk_i, preset_i    clock and synchronous active-high reset
//   req_valid_i         per-client request valid
//   req_ready_o         one-hot accept pulse (combinational, IDLE only)
//   req_write_i         per-client write flag
//   req_addr_i          packed per-client address
//   req_wdata_i         packed per-client write data
//   req_strb_i          packed per-client write strobes
//   rsp_valid_o         one-hot response pulse to the owning client
//   rsp_rdata_o         shared response data, zero outside a response
//   rsp_slverr_o        shared response error, zero outside a response
//   paddr_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o
//                       registered APB master outputs
//   prdata_i, pready_i, pslverr_i
//                       APB slave return signals

module apb_regs_arbiter #(
   parameter int NoReq         = 3,
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 16,
   localparam int StrbWidth    = (DataWidth + 7) / 8
) (
   input  logic                       pclk_i,
   input  logic                       preset_i,
   input  logic [NoReq-1:0]           req_valid_i,
   output logic [NoReq-1:0]           req_ready_o,
   input  logic [NoReq-1:0]           req_write_i,
   input  logic [NoReq*AddrWidth-1:0] req_addr_i,
   input  logic [NoReq*DataWidth-1:0] req_wdata_i,
   input  logic [NoReq*StrbWidth-1:0] req_strb_i,
   output logic [NoReq-1:0]           rsp_valid_o,
   output logic [DataWidth-1:0]       rsp_rdata_o,
   output logic                       rsp_slverr_o,
   output logic [AddrWidth-1:0]       paddr_o,
   output logic                       pwrite_o,
   output logic [DataWidth-1:0]       pwdata_o,
   output logic [StrbWidth-1:0]       pstrb_o,
   output logic                       psel_o,
   output logic                       penable_o,
   input  logic [DataWidth-1:0]       prdata_i,
   input  logic                       pready_i,
   input  logic                       pslverr_i
);

   localparam int IdxWidth = (NoReq > 1) ? $clog2(NoReq) : 1;
   localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam bit WdEnable = (TimeoutCycles > 0);
   localparam logic [CntWidth-1:0] WdLast =
      (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NoReq - 1);

   typedef enum logic [1:0] {
      Idle,
      Setup,
      Access
   } stateT;

   stateT               state;
   stateT               stateNext;
   logic [IdxWidth-1:0] rrPtr;
   logic [IdxWidth-1:0] owner;
   logic [IdxWidth-1:0] ownerInc;
   logic [IdxWidth-1:0] winIdx;
   logic [IdxWidth-1:0] scanIdx;
   logic                anyValid;
   logic                accept;
   logic                complete;
   logic                abort;
   logic [CntWidth-1:0] wdCount;

   // Round-robin search. Client ids are scanned starting at the pointer and
   // wrap modulo NoReq. The first requesting client found wins. Clients that
   // drop valid before they are accepted are simply passed over.
   always_comb begin
      winIdx   = '0;
      anyValid = 1'b0;
      scanIdx  = '0;
      for (int k = 0; k < NoReq; k++) begin
         scanIdx = IdxWidth'((int'(rrPtr) + k) % NoReq);
         if (!anyValid && req_valid_i[scanIdx]) begin
            anyValid = 1'b1;
            winIdx   = scanIdx;
         end
      end
   end

   // After a transfer ends, the pointer moves to the client just after the
   // owner. This keeps any client that requests continuously within NoReq
   // grants of service. With a single client it always wraps back to 0.
   always_comb begin
      ownerInc = (owner == LastIdx) ? '0 : owner + IdxWidth'(1);
   end

   // Next-state and decode logic. The accept pulse is combinational and only
   // appears in IDLE. It is held off while reset is asserted, so a client
   // never sees a grant that the reset then discards. ACCESS ends on pready.
   // It also ends when the watchdog reaches its last permitted cycle.
   always_comb begin
      stateNext   = state;
      accept      = 1'b0;
      complete    = 1'b0;
      abort       = 1'b0;
      req_ready_o = '0;
      unique case (state)
         Idle: begin
            if (anyValid && !preset_i) begin
               accept              = 1'b1;
               req_ready_o[winIdx] = 1'b1;
               stateNext           = Setup;
            end
         end
         Setup: begin
            stateNext = Access;
         end
         Access: begin
            if (pready_i) begin
               complete  = 1'b1;
               stateNext = Idle;
            end else if (WdEnable && (wdCount == WdLast)) begin
               abort     = 1'b1;
               stateNext = Idle;
            end
         end
         default: begin
            stateNext = Idle;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state <= Idle;
      end else begin
         state <= stateNext;
      end
   end

   // Datapath registers. The winner's payload is captured straight into the
   // APB output registers. That way SETUP already presents it and it stays
   // frozen through ACCESS. Response outputs are cleared by default every
   // cycle, so each response is exactly one pulse. A reset clears everything.
   // This also discards any transfer in flight without sending a response.
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         rrPtr        <= '0;
         owner        <= '0;
         wdCount      <= '0;
         psel_o       <= 1'b0;
         penable_o    <= 1'b0;
         paddr_o      <= '0;
         pwrite_o     <= 1'b0;
         pwdata_o     <= '0;
         pstrb_o      <= '0;
         rsp_valid_o  <= '0;
         rsp_rdata_o  <= '0;
         rsp_slverr_o <= 1'b0;
      end else begin
         rsp_valid_o  <= '0;
         rsp_rdata_o  <= '0;
         rsp_slverr_o <= 1'b0;

         if (accept) begin
            owner     <= winIdx;
            paddr_o   <= req_addr_i[winIdx*AddrWidth +: AddrWidth];
            pwrite_o  <= req_write_i[winIdx];
            pwdata_o  <= req_wdata_i[winIdx*DataWidth +: DataWidth];
            pstrb_o   <= req_strb_i[winIdx*StrbWidth +: StrbWidth];
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            wdCount   <= '0;
         end

         if (state == Setup) begin
            penable_o <= 1'b1;
         end

         if (state == Access) begin
            if (complete) begin
               psel_o              <= 1'b0;
               penable_o           <= 1'b0;
               rsp_valid_o[owner]  <= 1'b1;
               rsp_slverr_o        <= pslverr_i;
               rsp_rdata_o         <= pwrite_o ? '0 : prdata_i;
               rrPtr               <= ownerInc;
               wdCount             <= '0;
            end else if (abort) begin
               psel_o              <= 1'b0;
               penable_o           <= 1'b0;
               rsp_valid_o[owner]  <= 1'b1;
               rsp_slverr_o        <= 1'b1;
               rsp_rdata_o         <= '0;
               rrPtr               <= ownerInc;
               wdCount             <= '0;
            end else begin
               wdCount <= wdCount + CntWidth'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_regs_arbiter.sv
// tb_apb_regs_arbiter
// Self-checking bench for apb_regs_arbiter with default parameters
// (3 clients, 32-bit address/data, 16-cycle watchdog). A transaction-level
// reference model predicts these from the current requests:
//   - the round-robin winner
//   - the APB phases of each transfer
//   - the response of each transfer
// It is used for directed scenarios and for randomized traffic.

module tb_apb_regs_arbiter;

   localparam int NoReq         = 3;
   localparam int AddrWidth     = 32;
   localparam int DataWidth     = 32;
   localparam int StrbWidth     = 4;
   localparam int TimeoutCycles = 16;

   logic                       pclk_i = 1'b0;
   logic                       preset_i;
   logic [NoReq-1:0]           req_valid_i;
   logic [NoReq-1:0]           req_ready_o;
   logic [NoReq-1:0]           req_write_i;
   logic [NoReq*AddrWidth-1:0] req_addr_i;
   logic [NoReq*DataWidth-1:0] req_wdata_i;
   logic [NoReq*StrbWidth-1:0] req_strb_i;
   logic [NoReq-1:0]           rsp_valid_o;
   logic [DataWidth-1:0]       rsp_rdata_o;
   logic                       rsp_slverr_o;
   logic [AddrWidth-1:0]       paddr_o;
   logic                       pwrite_o;
   logic [DataWidth-1:0]       pwdata_o;
   logic [StrbWidth-1:0]       pstrb_o;
   logic                       psel_o;
   logic                       penable_o;
   logic [DataWidth-1:0]       prdata_i;
   logic                       pready_i;
   logic                       pslverr_i;

   int total = 0;
   int bad   = 0;
   int modelPtr;
   int winner;
   int grantCount[NoReq];

   logic [AddrWidth-1:0] cliAddr[NoReq];
   logic [DataWidth-1:0] cliWdata[NoReq];
   logic [StrbWidth-1:0] cliStrb[NoReq];
   logic                 cliWrite[NoReq];
   logic [NoReq-1:0]     cliMask;

   apb_regs_arbiter #(
      .NoReq(NoReq),
      .AddrWidth(AddrWidth),
      .DataWidth(DataWidth),
      .TimeoutCycles(TimeoutCycles)
   ) dut (
      .pclk_i(pclk_i),
      .preset_i(preset_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_write_i(req_write_i),
      .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .req_strb_i(req_strb_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_slverr_o(rsp_slverr_o),
      .paddr_o(paddr_o),
      .pwrite_o(pwrite_o),
      .pwdata_o(pwdata_o),
      .pstrb_o(pstrb_o),
      .psel_o(psel_o),
      .penable_o(penable_o),
      .prdata_i(prdata_i),
      .pready_i(pready_i),
      .pslverr_i(pslverr_i)
   );

   // Free-running 10 ns clock.
   always #5 pclk_i = ~pclk_i;

   // One comparison point: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives the client-side request ports from the per-client tables.
   task automatic applyStimulus();
      for (int i = 0; i < NoReq; i++) begin
         req_addr_i[i*AddrWidth +: AddrWidth]  = cliAddr[i];
         req_wdata_i[i*DataWidth +: DataWidth] = cliWdata[i];
         req_strb_i[i*StrbWidth +: StrbWidth]  = cliStrb[i];
         req_write_i[i]                        = cliWrite[i];
      end
      req_valid_i = cliMask;
   endtask

   // Fills every client's payload with random values.
   task automatic randomizePayload();
      for (int i = 0; i < NoReq; i++) begin
         cliAddr[i]  = $urandom;
         cliWdata[i] = $urandom;
         cliStrb[i]  = StrbWidth'($urandom_range(0, 15));
         cliWrite[i] = 1'($urandom_range(0, 1));
      end
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge pclk_i);
      #1;
   endtask

   // Round-robin rule: the first requesting client at or after the pointer,
   // wrapping around. Returns -1 when nobody requests.
   function automatic int modelWinner(input logic [NoReq-1:0] mask, input int ptr);
      for (int k = 0; k < NoReq; k++) begin
         if (mask[(ptr + k) % NoReq]) return (ptr + k) % NoReq;
      end
      return -1;
   endfunction

   // Holds reset for two edges, then checks that every output is clear.
   task automatic doReset();
      preset_i  = 1'b1;
      cliMask   = '0;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = '0;
      applyStimulus();
      tick();
      tick();
      checkOutput("reset_ctl", {rsp_valid_o, rsp_slverr_o, psel_o, penable_o, pwrite_o, pstrb_o}, '0);
      checkOutput("reset_addr_wdata", {paddr_o, pwdata_o}, '0);
      checkOutput("reset_rdata", rsp_rdata_o, '0);
      preset_i = 1'b0;
      modelPtr = 0;
   endtask

   // Runs one arbitration and, if a client is granted, its whole transfer.
   // The caller has already applied the requests at the start of an IDLE
   // cycle. The slave raises pready in ACCESS cycle 'waits' (0 = first), or
   // never when 'timeout' is set. The task returns one cycle after the
   // response pulse has been checked.
   task automatic doTransfer(input int waits, input logic err,
                             input logic [DataWidth-1:0] rdata,
                             input bit timeout, output int won);
      int w;
      int accessCycles;
      logic [AddrWidth-1:0] expAddr;
      logic [DataWidth-1:0] expWdata;
      logic [StrbWidth-1:0] expStrb;
      logic                 expWrite;
      logic [DataWidth-1:0] expRdata;
      logic                 expErr;
      #1;
      w = modelWinner(cliMask, modelPtr);
      won = w;
      if (w < 0) begin
         checkOutput("ready_none", req_ready_o, '0);
         return;
      end
      checkOutput("ready_grant", req_ready_o, 64'(1) << w);
      expAddr  = cliAddr[w];
      expWdata = cliWdata[w];
      expStrb  = cliStrb[w];
      expWrite = cliWrite[w];

      tick();
      checkOutput("setup_phase", {psel_o, penable_o}, 2'b10);
      checkOutput("setup_payload", {paddr_o, pwdata_o}, {expAddr, expWdata});
      checkOutput("setup_ctl", {pwrite_o, pstrb_o}, {expWrite, expStrb});
      checkOutput("setup_quiet", {req_ready_o, rsp_valid_o}, '0);

      tick();
      accessCycles = timeout ? TimeoutCycles : waits + 1;
      for (int c = 0; c < accessCycles; c++) begin
         checkOutput("access_phase", {psel_o, penable_o}, 2'b11);
         checkOutput("access_payload", {paddr_o, pwdata_o}, {expAddr, expWdata});
         checkOutput("access_ctl", {pwrite_o, pstrb_o, req_ready_o, rsp_valid_o},
                     {expWrite, expStrb, 6'b000000});
         pready_i  = !timeout && (c == waits);
         prdata_i  = pready_i ? rdata : $urandom;
         pslverr_i = pready_i ? err : 1'($urandom_range(0, 1));
         tick();
      end
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = $urandom;

      expRdata = (timeout || expWrite) ? '0 : rdata;
      expErr   = timeout ? 1'b1 : err;
      checkOutput("rsp_valid", rsp_valid_o, 64'(1) << w);
      checkOutput("rsp_rdata", rsp_rdata_o, expRdata);
      checkOutput("rsp_slverr", rsp_slverr_o, expErr);
      checkOutput("rsp_apb_idle", {psel_o, penable_o}, '0);
      modelPtr = (w + 1) % NoReq;
   endtask

   // Directed scenarios followed by randomized traffic, in one linear sequence.
   initial begin
      preset_i    = 1'b1;
      req_valid_i = '0;
      req_write_i = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_strb_i  = '0;
      prdata_i    = '0;
      pready_i    = 1'b0;
      pslverr_i   = 1'b0;
      for (int i = 0; i < NoReq; i++) grantCount[i] = 0;
      randomizePayload();
      doReset();

      $display("[TB] single read");
      cliMask     = 3'b001;
      cliAddr[0]  = 32'h0003_0004;
      cliWrite[0] = 1'b0;
      applyStimulus();
      doTransfer(0, 1'b0, 32'h0000_1234, 1'b0, winner);
      checkOutput("single_read_owner", winner, 0);

      $display("[TB] contention");
      doReset();
      randomizePayload();
      cliMask = 3'b111;
      applyStimulus();
      for (int t = 0; t < 6; t++) begin
         doTransfer($urandom_range(0, 2), 1'b0, $urandom, 1'b0, winner);
         checkOutput("contention_order", winner, t % NoReq);
         if (winner >= 0) grantCount[winner]++;
      end
      for (int i = 0; i < NoReq; i++) checkOutput("contention_share", grantCount[i], 2);

      $display("[TB] write with wait states");
      cliMask     = 3'b100;
      cliWrite[2] = 1'b1;
      cliWdata[2] = 32'hDEAD_BEEF;
      cliStrb[2]  = 4'b0101;
      applyStimulus();
      doTransfer(3, 1'b0, 32'hFFFF_FFFF, 1'b0, winner);
      checkOutput("write_owner", winner, 2);

      $display("[TB] slave error then pointer advance");
      randomizePayload();
      cliMask = 3'b011;
      applyStimulus();
      doTransfer(1, 1'b1, $urandom, 1'b0, winner);
      checkOutput("slverr_owner", winner, 0);
      doTransfer(0, 1'b0, $urandom, 1'b0, winner);
      checkOutput("after_err_owner", winner, 1);

      $display("[TB] watchdog");
      cliMask = 3'b111;
      applyStimulus();
      doTransfer(0, 1'b0, '0, 1'b1, winner);
      checkOutput("watchdog_owner", winner, 2);
      doTransfer(0, 1'b0, $urandom, 1'b0, winner);
      checkOutput("after_watchdog_owner", winner, 0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 30; n++) begin
         randomizePayload();
         cliMask = NoReq'($urandom_range(0, 7));
         applyStimulus();
         doTransfer($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 9) == 0), winner);
         if (winner < 0) begin
            tick();
            checkOutput("idle_quiet", {psel_o, penable_o, rsp_valid_o}, '0);
         end
      end

      $display("[TB] reset during access");
      randomizePayload();
      cliMask = 3'b010;
      applyStimulus();
      tick();
      tick();
      checkOutput("pre_reset_phase", {psel_o, penable_o}, 2'b11);
      preset_i = 1'b1;
      tick();
      checkOutput("midreset_ctl", {rsp_valid_o, rsp_slverr_o, psel_o, penable_o, pwrite_o, pstrb_o}, '0);
      checkOutput("midreset_payload", {paddr_o, pwdata_o}, '0);
      preset_i = 1'b0;
      cliMask  = '0;
      applyStimulus();
      pready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("postreset_quiet", {rsp_valid_o, psel_o, penable_o}, '0);
      end
      pready_i = 1'b0;
      modelPtr = 0;
      cliMask  = 3'b111;
      applyStimulus();
      doTransfer(0, 1'b0, $urandom, 1'b0, winner);
      checkOutput("postreset_owner", winner, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_regs_arbiter.md
Name: apb_regs_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB master port between NoReq simple request/response clients.
- Typical clients: core config port, debug bridge, DMA descriptor loader. Its APB side drives the APB register file slave directly.
- Converts each accepted request into a full APB SETUP/ACCESS transfer, waits for pready, and returns rdata and slverr to the winning client.
- A configurable watchdog aborts transfers whose slave never responds.

Parameters:
- NoReq, 3, number of requesting clients (≥1).
- AddrWidth, 32, APB address width.
- DataWidth, 32, APB data width.
- StrbWidth, ceil(DataWidth/8), APB strobe width (derived; not overridable).
- TimeoutCycles, 16, maximum ACCESS cycles without pready before abort; 0 disables the watchdog.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- preset_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NoReq  per-client request valid.
- req_ready_o  out  NoReq  per-client accept, one-hot, one-cycle pulse.
- req_write_i  in  NoReq  1 = write, 0 = read.
- req_addr_i  in  NoReq*AddrWidth  packed addresses; client i at slice [i*AddrWidth +: AddrWidth].
- req_wdata_i  in  NoReq*DataWidth  packed write data.
- req_strb_i  in  NoReq*StrbWidth  packed write strobes.
- rsp_valid_o  out  NoReq  one-hot response pulse to the client that owned the transfer.
- rsp_rdata_o  out  DataWidth  read data, shared by all clients; qualified by rsp_valid_o.
- rsp_slverr_o  out  1  error flag, shared; qualified by rsp_valid_o.
- paddr_o  out  AddrWidth  APB address.
- pwrite_o  out  1  APB write.
- pwdata_o  out  DataWidth  APB write data.
- pstrb_o  out  StrbWidth  APB strobes.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- prdata_i  in  DataWidth  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.

Behaviour:
- Reset (synchronous, sampled at a rising edge with preset_i=1):
  - FSM → IDLE.
  - All outputs 0.
  - Round-robin pointer = 0; watchdog counter = 0.
  - Reset asserted mid-transfer drops psel/penable on the next edge and never issues a response for that transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is set, select winner w = first set bit at or after the pointer, wrapping modulo NoReq.
  - req_ready_o[w]=1 combinationally this cycle; all other req_ready_o bits are 0.
  - Latch addr, write, wdata and strb of w.
  - Next state SETUP.
  - With no requests, stay in IDLE; req_ready_o = 0.
- SETUP: psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb driven from the latched values. Next state ACCESS unconditionally.
- ACCESS:
  - psel_o=1, penable_o=1; control, address, wdata and strb held stable.
  - If pready_i=1: register the response. Next cycle rsp_valid_o[w]=1, rsp_slverr_o=pslverr_i, rsp_rdata_o=prdata_i for reads and 0 for writes.
  - On completion: pointer ← (w+1) mod NoReq, watchdog cleared, next state IDLE.
  - Else if TimeoutCycles≠0 and counter == TimeoutCycles-1: abort. Next cycle rsp_valid_o[w]=1, rsp_slverr_o=1, rsp_rdata_o=0. psel/penable drop, pointer advances, next state IDLE.
  - Otherwise counter increments.
- Registered APB outputs: psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o.
- Response pulses: rsp_valid_o lasts exactly 1 cycle. rsp_rdata_o and rsp_slverr_o are 0 when no response is pulsed.
- Timing and throughput:
  - Minimum latency from accept edge to rsp_valid_o: 3 cycles (SETUP, ACCESS with pready, response).
  - The response cycle coincides with IDLE, so a new arbitration may occur in the same cycle as a response.
  - Sustained maximum: one transfer per 3 cycles.
- Client rules:
  - A client keeps req_valid_i and its payload stable until req_ready_o.
  - A client may drop req_valid_i before acceptance; it is then simply not chosen.
  - Request fields of non-winners are ignored.
- Fairness: any continuously requesting client is granted within NoReq transfers.
- NoReq=1: the pointer stays at 0.

Test Plan:
- Single read: client0 reads addr 0x0003_0004, slave returns 0x1234 with pready in the first ACCESS cycle → psel at T+1, penable at T+2, rsp_valid_o=3'b001 at T+3, rsp_rdata_o=0x1234, slverr=0.
- Contention: clients 0, 1 and 2 request continuously from reset → grant order 0,1,2,0,1,2. Each client gets exactly 2 accepts in 6 transfers; paddr_o matches the owner's address in every transfer.
- Write with wait states: client2 writes 0xDEAD_BEEF, strb 4'b0101, pready after 4 ACCESS cycles → pwdata/pstrb/paddr stable for all 4 cycles, rsp_rdata_o=0, one rsp_valid_o[2] pulse.
- Slave error: pslverr_i=1 with pready → rsp_slverr_o=1 for the owner only; the pointer still advances.
- Watchdog: TimeoutCycles=16, pready held at 0 → penable high exactly 16 cycles, then rsp_valid with slverr=1. psel_o=0 on the following cycle; the next client is granted after that.
- Reset mid-ACCESS: preset_i=1 while penable=1 → next edge all outputs 0, no rsp_valid_o pulse. After release, client0 wins first.
